// File: rtl/uart_rx_if.sv
// Byte-side bus of the UART receiver: received data, its valid/ready handshake,
// and the error/status outputs.
// Ports: master = receiver (drives data/status, takes ready); slave = consumer.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_data_ready;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_busy;

  modport master (
    output rx_data, rx_data_valid, rx_frame_err, rx_overrun, rx_busy,
    input  rx_data_ready
  );

  modport slave (
    input  rx_data, rx_data_valid, rx_frame_err, rx_overrun, rx_busy,
    output rx_data_ready
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronised rx_pin, mid-bit sampling, LSB-first byte rebuild.
// Latency: rx_data_valid rises 1 clk after the mid-stop-bit sample (~9.5 bit times + 3 clk).
// Backpressure: byte held with valid until valid&ready; a byte completing while still
//   held is dropped with a 1-clk rx_overrun pulse. Bad stop bit gives a 1-clk rx_frame_err.
// Ports: clk, rst_n (sync, active low), rx_pin (async serial in), rx_bus (uart_rx_if.master).
module uart_rx #(
  parameter int CLK_FRE   = 50,
  parameter int BAUD_RATE = 115200
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_pin,
  uart_rx_if.master     rx_bus
);

  localparam int CYCLES_PER_BIT = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int CNT_W          = $clog2(CYCLES_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CYCLES_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  logic [2:0]       state;
  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             frame_err_q;
  logic             overrun_q;
  logic             busy_q;
  logic             rxs;

  assign rxs = sync_q[1];

  assign rx_bus.rx_data       = data_q;
  assign rx_bus.rx_data_valid = valid_q;
  assign rx_bus.rx_frame_err  = frame_err_q;
  assign rx_bus.rx_overrun    = overrun_q;
  assign rx_bus.rx_busy       = busy_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      sync_q      <= 2'b11;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], rx_pin};
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      // Consumer handshake; a delivery below in the same cycle overrides this.
      if (valid_q && rx_bus.rx_data_ready) valid_q <= 1'b0;

      case (state)
        S_IDLE: begin
          if (!rxs) begin
            state  <= S_START;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end

        // Half-bit check re-centres all later samples on mid-bit.
        S_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rxs) begin
              state <= S_DATA;
              idx   <= '0;
            end else begin
              state  <= S_IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt        <= '0;
            shreg[idx] <= rxs;
            if (idx == 3'd7) state <= S_STOP;
            else             idx   <= idx + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Leaving at mid-stop-bit lets the next start edge be caught with no idle gap.
        S_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rxs) begin
              state  <= S_IDLE;
              busy_q <= 1'b0;
              if (!valid_q || rx_bus.rx_data_ready) begin
                data_q  <= shreg;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
              state       <= S_WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Wait out a stuck-low line so it is not mistaken for a new start bit.
        S_WAIT_HIGH: begin
          if (rxs) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        end

        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames, scoreboard queue of expected bytes popped by
// an independent monitor on every valid&ready cycle; error pulses counted by the monitor.
module tb_uart_rx;
  localparam int CPB = 434;

  logic clk;
  logic rst_n;
  logic rx_pin;

  uart_rx_if bus ();

  uart_rx #(.CLK_FRE(50), .BAUD_RATE(115200)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_pin (rx_pin),
    .rx_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
  endtask

  // Monitor: independent of stimulus; pops expectations on each accepted byte.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rx_frame_err) fe_cnt++;
      if (bus.rx_overrun)   ov_cnt++;
      if (bus.rx_data_valid && bus.rx_data_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_valid: got=%0h expected=none", bus.rx_data);
        end else begin
          check("rx_data", {24'd0, bus.rx_data}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx_pin = b;
    tick(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_bit);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 4 * CPB) begin
      tick(1);
      t++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_data"},      {24'd0, bus.rx_data}, 0);
    check({tag, "_valid"},     {31'd0, bus.rx_data_valid}, 0);
    check({tag, "_frame_err"}, {31'd0, bus.rx_frame_err}, 0);
    check({tag, "_overrun"},   {31'd0, bus.rx_overrun}, 0);
    check({tag, "_busy"},      {31'd0, bus.rx_busy}, 0);
    tick(1);
  endtask

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    rx_pin = 1'b1;
    bus.rx_data_ready = 1'b1;
    tick(5);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(10);

    // 1: single byte, ready high
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1);
    tick(CPB);
    drain("t1_drain");
    check("t1_frame_err", fe_cnt, 0);
    check("t1_overrun", ov_cnt, 0);

    // 2: back-to-back frames, no idle gap
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h0F);
    send_byte(8'hA3, 1'b1);
    send_byte(8'h0F, 1'b1);
    tick(CPB);
    drain("t2_drain");

    // 3: 100-clk glitch rejected
    rx_pin = 1'b0;
    tick(50);
    @(negedge clk);
    check("t3_busy_during", {31'd0, bus.rx_busy}, 1);
    tick(50);
    rx_pin = 1'b1;
    tick(CPB);
    @(negedge clk);
    check("t3_busy_after", {31'd0, bus.rx_busy}, 0);
    check("t3_frame_err", fe_cnt, 0);
    tick(1);

    // 4: bad stop bit, line held low another bit, then a good byte
    send_byte(8'h3C, 1'b0);
    send_bit(1'b0);
    rx_pin = 1'b1;
    tick(2 * CPB);
    check("t4_frame_err", fe_cnt, 1);
    exp_q.push_back(8'h81);
    send_byte(8'h81, 1'b1);
    tick(CPB);
    drain("t4_drain");
    check("t4_frame_err_final", fe_cnt, 1);

    // 5: overrun with ready low
    bus.rx_data_ready = 1'b0;
    send_byte(8'h11, 1'b1);
    tick(CPB);
    send_byte(8'h22, 1'b1);
    tick(CPB);
    @(negedge clk);
    check("t5_data_held", {24'd0, bus.rx_data}, 32'h11);
    check("t5_valid_held", {31'd0, bus.rx_data_valid}, 1);
    check("t5_overrun", ov_cnt, 1);
    check("t5_frame_err", fe_cnt, 1);
    @(posedge clk);
    #1;
    exp_q.push_back(8'h11);
    bus.rx_data_ready = 1'b1;
    tick(1);
    @(negedge clk);
    check("t5_valid_dropped", {31'd0, bus.rx_data_valid}, 0);
    drain("t5_drain");

    // 6: reset during data bit 4, then a clean byte
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx_pin = 1'b0;
    tick(CPB / 2);
    rst_n = 1'b0;
    tick(3);
    check_reset_outputs("t6_reset");
    rx_pin = 1'b1;
    rst_n = 1'b1;
    tick(2 * CPB);
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, 1'b1);
    tick(CPB);
    drain("t6_drain");
    check("t6_frame_err", fe_cnt, 1);
    check("t6_overrun", ov_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
